// File: rtl/sobolrng_ctrl.sv
// Sobol sequence generator with a valid/ready sample stream and programmable run length.
// Optional build macro SOBOLRNG_CTRL_SCRAMBLE_EN adds iSeed, which becomes sample 0 of each run.
module sobolrng_ctrl #(
  parameter int BITWIDTH = 8,
  parameter int IDXW     = 3
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iCfgWe,
  input  logic [IDXW-1:0]     iCfgIdx,
  input  logic [BITWIDTH-1:0] iCfgData,
  input  logic                iStart,
  input  logic [BITWIDTH-1:0] iLen,
  input  logic                iReady,
`ifdef SOBOLRNG_CTRL_SCRAMBLE_EN
  input  logic [BITWIDTH-1:0] iSeed,
`endif
  output logic                oValid,
  output logic [BITWIDTH-1:0] oRand,
  output logic                oLast,
  output logic                oBusy,
  output logic                oDone
);

  localparam int KW = BITWIDTH + 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [KW-1:0]   K_ONE   = {{BITWIDTH{1'b0}}, 1'b1};
  localparam logic [KW-1:0]   K_FULL  = {1'b1, {BITWIDTH{1'b0}}};
  localparam logic [IDXW:0]   DIR_CNT = (IDXW+1)'(BITWIDTH);

  // Index of the lowest set bit; selects the direction vector for the next sample.
  function automatic logic [IDXW-1:0] tz_f(input logic [BITWIDTH-1:0] v);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = BITWIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = IDXW'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [KW-1:0]       len_r;
  logic [KW-1:0]       k_r;
  logic [BITWIDTH-1:0] dir_r [BITWIDTH];
  logic                valid_r;
  logic [BITWIDTH-1:0] rand_r;
  logic                last_r;
  logic                busy_r;
  logic                done_r;

  logic                hs_s;
  logic [KW-1:0]       k_inc_s;
  logic [BITWIDTH-1:0] step_s;
  logic [KW-1:0]       start_len_s;
  logic [BITWIDTH-1:0] seed_s;
  logic                cfg_ok_s;

  // Handshake, next-sample arithmetic and FSM next state.
  always_comb begin
    hs_s        = valid_r & iReady;
    k_inc_s     = k_r + K_ONE;
    step_s      = rand_r ^ dir_r[tz_f(k_inc_s[BITWIDTH-1:0])];
    cfg_ok_s    = iCfgWe & ({1'b0, iCfgIdx} < DIR_CNT);
    // A zero length stands for the full 2^BITWIDTH period.
    if (iLen == {BITWIDTH{1'b0}}) begin
      start_len_s = K_FULL;
    end else begin
      start_len_s = {1'b0, iLen};
    end
`ifdef SOBOLRNG_CTRL_SCRAMBLE_EN
    seed_s      = iSeed;
`else
    seed_s      = {BITWIDTH{1'b0}};
`endif
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (iStart) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hs_s && last_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Sequencer state, direction-vector table and registered stream outputs.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_r <= ST_IDLE;
      len_r   <= '0;
      k_r     <= '0;
      for (int i = 0; i < BITWIDTH; i++) begin
        dir_r[i] <= '0;
      end
      valid_r <= 1'b0;
      rand_r  <= '0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cfg_ok_s) begin
            dir_r[iCfgIdx] <= iCfgData;
          end
          if (iStart) begin
            len_r   <= start_len_s;
            k_r     <= '0;
            rand_r  <= seed_s;
            valid_r <= 1'b1;
            last_r  <= (start_len_s == K_ONE);
          end
        end
        ST_RUN: begin
          if (hs_s) begin
            if (last_r) begin
              valid_r <= 1'b0;
              last_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              k_r    <= k_inc_s;
              rand_r <= step_s;
              last_r <= ((k_inc_s + K_ONE) == len_r);
            end
          end
        end
        ST_DONE: begin
          valid_r <= 1'b0;
          last_r  <= 1'b0;
        end
        default: begin
          valid_r <= 1'b0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign oValid = valid_r;
  assign oRand  = rand_r;
  assign oLast  = last_r;
  assign oBusy  = busy_r;
  assign oDone  = done_r;

endmodule
